// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Ratios below 2 cannot produce a toggling output, so they are raised to 2.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
    return (r < 32'd2) ? 32'd2 : r;
  endfunction

  // Channel i comes out of reset dividing by 2^(i+1).
  function automatic logic [31:0] reset_ratio(input int unsigned i);
    return 32'd2 << i;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: run/drain FSM, period counter, active and pending ratio.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIVW = 8,
  parameter int unsigned IDX  = 0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic            cfg_acc_i,
  input  logic [DIVW-1:0] cfg_ratio_i,
  output logic            pending_o,
  output logic            clk_out_o,
  output logic            tick_o
);

  localparam int unsigned HW = DIVW + 1;

  state_e            state_q, state_d;
  logic [DIVW-1:0]   cnt_q, cnt_d;
  logic [DIVW-1:0]   r_q, r_d;
  logic [DIVW-1:0]   p_q, p_d;
  logic              pend_q, pend_d;
  logic              clk_q, clk_d;
  logic              tick_q, tick_d;
  logic              wrap_c;
  logic              load_c;
  logic [HW-1:0]     high_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    p_d     = p_q;
    pend_d  = pend_q;
    load_c  = 1'b0;
    wrap_c  = (cnt_q == (r_q - DIVW'(1)));

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        load_c = pend_q;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        // Enable is only honoured at the period boundary; mid-period it just selects RUN vs DRAIN.
        if (wrap_c) begin
          cnt_d   = '0;
          load_c  = pend_q;
          state_d = en_i ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + DIVW'(1);
          state_d = en_i ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load_c) begin
      r_d    = p_q;
      pend_d = 1'b0;
    end
    if (cfg_acc_i) begin
      p_d    = DIVW'(clamp_ratio(32'(cfg_ratio_i)));
      pend_d = 1'b1;
    end

    high_c = (HW'(r_d) + HW'(1)) >> 1;
    clk_d  = (state_d != ST_IDLE) && (HW'(cnt_d) < high_c);
    tick_d = (state_d == ST_RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= DIVW'(reset_ratio(IDX));
      p_q     <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent programmable clock dividers sharing one config request port.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter  int unsigned NCH  = 3,
  parameter  int unsigned DIVW = 8,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NCH-1:0]  en_i,
  input  logic            cfg_valid_i,
  input  logic [CHW-1:0]  cfg_ch_i,
  input  logic [DIVW-1:0] cfg_ratio_i,
  output logic            cfg_ready_o,
  output logic [NCH-1:0]  pending_o,
  output logic [NCH-1:0]  clk_out_o,
  output logic [NCH-1:0]  tick_o
);

  logic [NCH-1:0] pend_w;
  logic [NCH-1:0] acc_c;
  logic           ready_c;

  // Out-of-range channel numbers stay ready so the request is consumed and dropped.
  always_comb begin
    ready_c = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch_i == CHW'(i)) ready_c = !pend_w[i];
    end
  end

  always_comb begin
    acc_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      acc_c[i] = cfg_valid_i && rst_n_i && (cfg_ch_i == CHW'(i)) && !pend_w[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkdiv_chan #(
      .DIVW (DIVW),
      .IDX  (g)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (en_i[g]),
      .cfg_acc_i   (acc_c[g]),
      .cfg_ratio_i (cfg_ratio_i),
      .pending_o   (pend_w[g]),
      .clk_out_o   (clk_out_o[g]),
      .tick_o      (tick_o[g])
    );
  end

  assign pending_o   = pend_w;
  assign cfg_ready_o = ready_c;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed scoreboard bench for clkdiv_multi: stimulus queues expected per-cycle outputs, a monitor checks them.
module tb_clkdiv_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en = '0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd3;
  logic [7:0] cfg_ratio = '0;
  logic       cfg_ready;
  logic [2:0] pending;
  logic [2:0] clk_out;
  logic [2:0] tick;

  typedef struct {
    logic [2:0] mask;
    logic [2:0] clk;
    logic [2:0] tick;
    logic [2:0] pend;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  clkdiv_multi #(.NCH(3), .DIVW(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .cfg_valid_i (cfg_valid),
    .cfg_ch_i    (cfg_ch),
    .cfg_ratio_i (cfg_ratio),
    .cfg_ready_o (cfg_ready),
    .pending_o   (pending),
    .clk_out_o   (clk_out),
    .tick_o      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [2:0] act, input logic [2:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s %s act=%b exp=%b t=%0t", nm, fld, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic [2:0] e, input logic v, input logic [1:0] ch,
                      input logic [7:0] ratio, input logic [2:0] mask, input logic [2:0] eclk,
                      input logic [2:0] etick, input logic [2:0] epend, input logic erdy, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n     = rst;
    en        = e;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_ratio = ratio;
    x.mask = mask;
    x.clk  = eclk;
    x.tick = etick;
    x.pend = epend;
    x.rdy  = erdy;
    x.nm   = nm;
    exp_q.push_back(x);
  endtask

  // Per-channel waveform strings; an empty string leaves that channel unchecked.
  task automatic play(input logic [2:0] e, input string c0, input string c1, input string c2,
                      input string t0, input string t1, input string t2,
                      input logic [2:0] epend, input string nm);
    string cs[3];
    string ts[3];
    int    n;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    ts[0] = t0; ts[1] = t1; ts[2] = t2;
    n = c0.len();
    if (c1.len() > n) n = c1.len();
    if (c2.len() > n) n = c2.len();
    for (int i = 0; i < n; i++) begin
      logic [2:0] m;
      logic [2:0] ec;
      logic [2:0] et;
      m = '0; ec = '0; et = '0;
      for (int k = 0; k < 3; k++) begin
        if (cs[k].len() > i) begin
          m[k]  = 1'b1;
          ec[k] = (cs[k].substr(i, i) == "1");
          et[k] = (ts[k].substr(i, i) == "1");
        end
      end
      step(1'b1, e, 1'b0, 2'd3, 8'd0, m, ec, et, epend, 1'b1, nm);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk(e.nm, "clk_out", clk_out & e.mask, e.clk & e.mask);
        chk(e.nm, "tick", tick & e.mask, e.tick & e.mask);
        chk(e.nm, "pending", pending, e.pend);
        chk(e.nm, "cfg_ready", {2'b00, cfg_ready}, {2'b00, e.rdy});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout, %0d vectors pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset defaults then /2, /4, /8 free-running
    step(1'b0, 3'b000, 1'b0, 2'd3, 8'd0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "reset0");
    step(1'b0, 3'b000, 1'b0, 2'd3, 8'd0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "reset1");
    play(3'b111, "1010101010101010", "1100110011001100", "1111000011110000",
                 "1010101010101010", "1000100010001000", "1000000010000000", 3'b000, "A_defaults");

    // Odd ratio 5 on ch0, requested mid-period
    play(3'b111, "1", "", "", "1", "", "", 3'b000, "B_wrap");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd5, 3'b001, 3'b000, 3'b000, 3'b001, 1'b0, "B_cfg5");
    play(3'b111, "1110011100", "", "", "1000010000", "", "", 3'b000, "B_odd5");

    // Clamp of 0, backpressure on ch0, immediate accept on ch1
    play(3'b111, "1", "", "", "1", "", "", 3'b000, "C_wrap");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000, 3'b001, 1'b0, "C_cfg0");
    step(1'b1, 3'b111, 1'b1, 2'd1, 8'd4, 3'b001, 3'b001, 3'b000, 3'b011, 1'b0, "C_other_ch");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd7, 3'b001, 3'b000, 3'b000, 3'b011, 1'b0, "C_blocked_a");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd7, 3'b001, 3'b000, 3'b000, 3'b001, 1'b0, "C_blocked_b");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd7, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1, "C_clamp_load");
    step(1'b1, 3'b111, 1'b1, 2'd0, 8'd7, 3'b001, 3'b000, 3'b000, 3'b001, 1'b0, "C_accept7");
    play(3'b111, "1111000", "", "", "1000000", "", "", 3'b000, "C_ratio7");

    // Drain on ch2 (/8): drop en at cnt=2, then re-assert during a later drain
    play(3'b111, "", "", "1", "", "", "0", 3'b000, "D_run");
    play(3'b011, "", "", "100000000", "", "", "000000000", 3'b000, "D_drain");
    play(3'b111, "", "", "11", "", "", "10", 3'b000, "D_restart");
    play(3'b011, "", "", "11", "", "", "00", 3'b000, "D_drop");
    play(3'b111, "", "", "000011", "", "", "000010", 3'b000, "D_reassert");

    // Accept on the wrap edge: one more /8 period, then /6
    play(3'b111, "", "", "110000", "", "", "000000", 3'b000, "E_run");
    step(1'b1, 3'b111, 1'b1, 2'd2, 8'd6, 3'b100, 3'b100, 3'b100, 3'b100, 1'b0, "E_cfg_on_wrap");
    play(3'b111, "", "", "1110000", "", "", "0000000", 3'b100, "E_old_period");
    play(3'b111, "", "", "1110001", "", "", "1000001", 3'b000, "E_ratio6");

    // Synchronous reset at ch2 cnt=3, cfg during reset ignored, defaults resume
    step(1'b0, 3'b000, 1'b0, 2'd3, 8'd0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "F_reset");
    play(3'b111, "1010", "1100", "1111", "1010", "1000", "1000", 3'b000, "F_run");
    step(1'b0, 3'b111, 1'b1, 2'd2, 8'd9, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, "F_reset_mid");
    play(3'b111, "10101010", "11001100", "11110000",
                 "10101010", "10001000", "10000000", 3'b000, "F_resume");

    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
